sobel_filter_nch: RTL



---
 rtl/sobel_filter_nch.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sobel_filter_nch.sv
// sobel_filter_nch: streaming multi-channel 3x3 Sobel edge filter.
// Pixels arrive in raster order. Each channel keeps two line buffers that hold
// the previous two rows, plus a two-column window history. Every accepted pixel
// with x>=2 and y>=2 completes one 3x3 window. That window's result is
// registered into a single-entry output stage.
//
// Handshake: a transfer happens on a rising edge where vld=1 and busy=0, on both
// sides. i_pix_busy is combinational (o_result_vld & o_result_busy), so the
// input stalls only while a finished result is still waiting downstream.
module sobel_filter_nch #(
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int THRESH   = 128
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_mode,
  input  logic                         i_pix_vld,
  output logic                         i_pix_busy,
  input  logic [CHANNELS*DATA_W-1:0]   i_pix_data,
  input  logic                         o_result_busy,
  output logic                         o_result_vld,
  output logic [CHANNELS*DATA_W-1:0]   o_result_data,
  output logic                         o_result_last
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int GW   = DATA_W + 4;
  localparam int PW   = CHANNELS * DATA_W;
  localparam int MAXV = (1 << DATA_W) - 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          mode_q;
  logic          in_xfer;
  logic          out_xfer;
  logic          produce;
  logic          frame_end;
  logic [PW-1:0] result;

  assign i_pix_busy = o_result_vld & o_result_busy;
  assign in_xfer    = i_pix_vld & ~i_pix_busy;
  assign out_xfer   = o_result_vld & ~o_result_busy;
  assign frame_end  = (x == X_LAST) && (y == Y_LAST);
  // Only STREAM can have y>=2. The state term keeps the FSM authoritative.
  assign produce    = in_xfer && (x >= XW'(2)) && (y >= YW'(2)) && (state == STREAM);

  // Frame FSM. The mode is captured with pixel (0,0) and held for the whole frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
    end else if (in_xfer) begin
      case (state)
        IDLE: begin
          if (x == '0 && y == '0) begin
            state  <= FILL;
            mode_q <= i_mode;
          end
        end
        FILL: begin
          if (x == X_LAST && y == YW'(1)) state <= STREAM;
        end
        STREAM: begin
          if (frame_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster position counters. They advance only on an accepted input pixel.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      x <= '0;
      y <= '0;
    end else if (in_xfer) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_W-1:0] lb0 [IMG_W];   // row y-1
    logic [DATA_W-1:0] lb1 [IMG_W];   // row y-2
    logic [DATA_W-1:0] pix, top, mid;
    logic [DATA_W-1:0] wa0, wa1, wa2; // column x-2, rows top..bottom
    logic [DATA_W-1:0] wb0, wb1, wb2; // column x-1, rows top..bottom
    logic [GW-1:0]     sum_r, sum_l, sum_b, sum_t;
    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]     ax, ay, mag;
    logic [DATA_W-1:0] res;

    assign pix = i_pix_data[c*DATA_W +: DATA_W];
    assign top = lb1[x];
    assign mid = lb0[x];

    // Shift the column history and push the new pixel down the line buffers.
    // These registers are always rewritten before they are used, so they have no reset.
    always_ff @(posedge i_clk) begin
      if (in_xfer) begin
        lb1[x] <= mid;
        lb0[x] <= pix;
        wa0    <= wb0;
        wa1    <= wb1;
        wa2    <= wb2;
        wb0    <= top;
        wb1    <= mid;
        wb2    <= pix;
      end
    end

    // Sobel gradients on the window {wa, wb, incoming column}. Then take the
    // magnitude and apply the output mode.
    always_comb begin
      sum_r = GW'(top) + (GW'(mid) << 1) + GW'(pix);
      sum_l = GW'(wa0) + (GW'(wa1) << 1) + GW'(wa2);
      sum_b = GW'(wa2) + (GW'(wb2) << 1) + GW'(pix);
      sum_t = GW'(wa0) + (GW'(wb0) << 1) + GW'(top);
      gx    = $signed(sum_r - sum_l);
      gy    = $signed(sum_b - sum_t);
      ax    = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay    = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
      mag   = ax + ay;
      res   = '0;
      if (mode_q) begin
        res = (mag >= GW'(THRESH)) ? '1 : '0;
      end else begin
        res = (mag > GW'(MAXV)) ? '1 : mag[DATA_W-1:0];
      end
    end

    assign result[c*DATA_W +: DATA_W] = res;
  end

  // Single-entry output register. A new result loads even while the old one
  // leaves, so there is no bubble. Otherwise a completed output transfer empties it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_result_vld  <= 1'b0;
      o_result_data <= '0;
      o_result_last <= 1'b0;
    end else if (produce) begin
      o_result_vld  <= 1'b1;
      o_result_data <= result;
      o_result_last <= frame_end;
    end else if (out_xfer) begin
      o_result_vld  <= 1'b0;
      o_result_last <= 1'b0;
    end
  end

endmodule
